// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: grants one of two requesters (LSU, fetch) a single outstanding memory transaction.
// Revision 1.0
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // fetch requester
  input  logic                f_req_valid,
  input  logic [ADDR_W-1:0]   f_req_addr,
  output logic                f_req_ready,
  output logic                f_rsp_valid,
  output logic [DATA_W-1:0]   f_rsp_rdata,
  input  logic                f_rsp_ready,
  // LSU requester
  input  logic                l_req_valid,
  input  logic [ADDR_W-1:0]   l_req_addr,
  input  logic                l_req_wen,
  input  logic [DATA_W-1:0]   l_req_wdata,
  input  logic [DATA_W/8-1:0] l_req_wmask,
  output logic                l_req_ready,
  output logic                l_rsp_valid,
  output logic [DATA_W-1:0]   l_rsp_rdata,
  input  logic                l_rsp_ready,
  // memory side
  output logic                m_req_valid,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic                m_req_wen,
  output logic [DATA_W-1:0]   m_req_wdata,
  output logic [DATA_W/8-1:0] m_req_wmask,
  input  logic                m_req_ready,
  input  logic                m_rsp_valid,
  input  logic [DATA_W-1:0]   m_rsp_rdata,
  output logic                m_rsp_ready
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic              last_lsu;
  logic              grant_lsu;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;
  logic [DATA_W-1:0] rdata_q;

  logic pick_lsu;
  logic grant_en;
  logic rsp_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // LSU normally wins, but yields to a waiting fetch right after its own grant.
  always_comb begin
    state_next  = state;
    pick_lsu    = l_req_valid && !(f_req_valid && last_lsu);
    grant_en    = 1'b0;
    rsp_take    = 1'b0;
    f_req_ready = 1'b0;
    l_req_ready = 1'b0;
    f_rsp_valid = 1'b0;
    f_rsp_rdata = '0;
    l_rsp_valid = 1'b0;
    l_rsp_rdata = '0;
    m_req_valid = 1'b0;
    m_req_addr  = '0;
    m_req_wen   = 1'b0;
    m_req_wdata = '0;
    m_req_wmask = '0;
    m_rsp_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (f_req_valid || l_req_valid) begin
            grant_en    = 1'b1;
            f_req_ready = !pick_lsu;
            l_req_ready = pick_lsu;
            state_next  = REQ;
          end
        end
        REQ: begin
          m_req_valid = 1'b1;
          m_req_addr  = addr_q;
          m_req_wen   = wen_q;
          m_req_wdata = wdata_q;
          m_req_wmask = wmask_q;
          if (m_req_ready) begin
            state_next = RSP;
          end
        end
        RSP: begin
          m_rsp_ready = 1'b1;
          if (m_rsp_valid) begin
            rsp_take   = 1'b1;
            state_next = DONE;
          end
        end
        DONE: begin
          if (grant_lsu) begin
            l_rsp_valid = 1'b1;
            l_rsp_rdata = rdata_q;
            if (l_rsp_ready) begin
              state_next = IDLE;
            end
          end else begin
            f_rsp_valid = 1'b1;
            f_rsp_rdata = rdata_q;
            if (f_rsp_ready) begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Request fields are captured at grant so later requester activity cannot disturb them.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu  <= 1'b0;
      grant_lsu <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (grant_en) begin
        last_lsu  <= pick_lsu;
        grant_lsu <= pick_lsu;
        addr_q    <= pick_lsu ? l_req_addr : f_req_addr;
        wen_q     <= pick_lsu & l_req_wen;
        wdata_q   <= pick_lsu ? l_req_wdata : '0;
        wmask_q   <= pick_lsu ? l_req_wmask : '0;
      end
      if (rsp_take) begin
        rdata_q <= m_rsp_rdata;
      end
    end
  end

endmodule
`default_nettype wire
